// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the architectural PC, fetches one word at a time
// over imem req/ack and presents it to decode over inst_valid/inst_ready.
module fetch_unit #(
  parameter logic [29:0] RESET_PC = 30'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] next_pc,
  input  logic        redirect,
  input  logic [29:0] redirect_pc,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  input  logic        inst_ready,
  output logic [29:0] pc,
  output logic [29:0] incr_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    VALID,
    DRAIN
  } state_t;

  state_t      state, state_next;
  logic        req_next, valid_next;
  logic [29:0] pending_pc;

  assign imem_addr = pc;
  assign incr_pc   = pc + 30'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
    end else begin
      state      <= state_next;
      imem_req   <= req_next;
      inst_valid <= valid_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  state_next = FETCH;
      FETCH: begin
        if (imem_ack && !redirect)      state_next = VALID;
        else if (!imem_ack && redirect) state_next = DRAIN;
      end
      DRAIN: if (imem_ack) state_next = FETCH;
      VALID: if (redirect || inst_ready) state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  // req/valid are registered, so they are decoded from the state being entered.
  always_comb begin
    req_next   = (state_next == FETCH) || (state_next == DRAIN);
    valid_next = (state_next == VALID);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      pending_pc  <= '0;
      inst        <= '0;
      fetch_count <= '0;
    end else begin
      case (state)
        IDLE: if (redirect) pc <= redirect_pc;
        FETCH: begin
          if (imem_ack) begin
            if (redirect) pc <= redirect_pc;
            else          inst <= imem_rdata;
          end else if (redirect) begin
            pending_pc <= redirect_pc;
          end
        end
        // The outstanding request keeps its address; the latest redirect wins.
        DRAIN: begin
          if (imem_ack)      pc <= redirect ? redirect_pc : pending_pc;
          else if (redirect) pending_pc <= redirect_pc;
        end
        VALID: begin
          if (redirect) begin
            pc <= redirect_pc;
          end else if (inst_ready) begin
            pc          <= next_pc;
            fetch_count <= fetch_count + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// checked against a transaction-level model of the fetch stream.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] next_pc;
  logic        redirect;
  logic [29:0] redirect_pc;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic        inst_ready;
  logic [29:0] pc;
  logic [29:0] incr_pc;
  logic [31:0] fetch_count;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  fetch_unit #(.RESET_PC(30'h100)) dut (
    .clk(clk), .reset(reset), .next_pc(next_pc), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
    .inst(inst), .inst_ready(inst_ready), .pc(pc), .incr_pc(incr_pc),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memword(input logic [29:0] a);
    return {a, 2'b01} ^ 32'hC3A5_0F1E;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_ack = 1'b0;
    imem_rdata = '0; inst_ready = 1'b0; next_pc = '0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", imem_req); end
    n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", inst_valid); end
    n_vec++; if (pc !== 30'h100) begin n_err++; $display("FAIL reset_pc got %h want 100", pc); end
    n_vec++; if (fetch_count !== 32'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", fetch_count); end
    n_vec++; if (inst !== 32'd0) begin n_err++; $display("FAIL reset_inst got %h want 0", inst); end
    step();
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 30'h100) begin
      n_err++; $display("FAIL first_req got req=%b addr=%h want req=1 addr=100", imem_req, imem_addr); end
  endtask

  task automatic test_stream();
    do_reset(); step();
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (imem_req !== 1'b1 || imem_addr !== 30'h100 + 30'(i) || inst_valid !== 1'b0) begin
        n_err++; $display("FAIL stream_fetch%0d got req=%b addr=%h valid=%b want req=1 addr=%h valid=0",
                          i, imem_req, imem_addr, inst_valid, 30'h100 + 30'(i)); end
      imem_ack = 1'b1; imem_rdata = memword(imem_addr);
      step();
      imem_ack = 1'b0; next_pc = incr_pc;
      n_vec++; if (inst_valid !== 1'b1 || imem_req !== 1'b0 || inst !== memword(30'h100 + 30'(i))) begin
        n_err++; $display("FAIL stream_valid%0d got valid=%b req=%b inst=%h want 1 0 %h",
                          i, inst_valid, imem_req, inst, memword(30'h100 + 30'(i))); end
      step();
    end
    n_vec++; if (fetch_count !== 32'd3 || imem_addr !== 30'h103) begin
      n_err++; $display("FAIL stream_count got count=%0d addr=%h want 3 103", fetch_count, imem_addr); end
    inst_ready = 1'b0;
  endtask

  task automatic test_stall();
    do_reset(); step();
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (imem_req !== 1'b1 || imem_addr !== 30'h100) begin
        n_err++; $display("FAIL stall_wait%0d got req=%b addr=%h want 1 100", i, imem_req, imem_addr); end
      step();
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0; imem_rdata = '0;
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (inst_valid !== 1'b1 || inst !== 32'hDEAD_BEEF || pc !== 30'h100 || fetch_count !== 32'd0) begin
        n_err++; $display("FAIL stall_hold%0d got valid=%b inst=%h pc=%h count=%0d want 1 deadbeef 100 0",
                          i, inst_valid, inst, pc, fetch_count); end
      step();
    end
  endtask

  task automatic test_branch();
    do_reset(); step();
    redirect = 1'b1; redirect_pc = 30'h200; imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
    step();
    redirect = 1'b0;
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 30'h200 || inst_valid !== 1'b0) begin
      n_err++; $display("FAIL ack_redirect got req=%b addr=%h valid=%b want 1 200 0", imem_req, imem_addr, inst_valid); end
    imem_rdata = memword(30'h200);
    step();
    imem_ack = 1'b0;
    n_vec++; if (inst_valid !== 1'b1 || pc !== 30'h200 || inst !== memword(30'h200)) begin
      n_err++; $display("FAIL branch_valid got valid=%b pc=%h inst=%h want 1 200 %h", inst_valid, pc, inst, memword(30'h200)); end
    inst_ready = 1'b1; next_pc = 30'h040;
    step();
    inst_ready = 1'b0;
    n_vec++; if (imem_addr !== 30'h040 || incr_pc !== 30'h041 || fetch_count !== 32'd1) begin
      n_err++; $display("FAIL branch_target got addr=%h incr=%h count=%0d want 040 041 1", imem_addr, incr_pc, fetch_count); end
  endtask

  task automatic test_drain();
    do_reset();
    redirect = 1'b1; redirect_pc = 30'h10;
    step();
    redirect_pc = 30'h3F0;
    step();
    redirect_pc = 30'h3F8;
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 30'h10) begin
      n_err++; $display("FAIL drain_hold0 got req=%b addr=%h want 1 010", imem_req, imem_addr); end
    step();
    redirect = 1'b0;
    n_vec++; if (imem_addr !== 30'h10) begin n_err++; $display("FAIL drain_hold1 got %h want 010", imem_addr); end
    step();
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    step();
    imem_ack = 1'b0;
    n_vec++; if (imem_req !== 1'b1 || imem_addr !== 30'h3F8 || inst_valid !== 1'b0) begin
      n_err++; $display("FAIL drain_retarget got req=%b addr=%h valid=%b want 1 3f8 0", imem_req, imem_addr, inst_valid); end
    imem_ack = 1'b1; imem_rdata = memword(30'h3F8);
    step();
    imem_ack = 1'b0;
    n_vec++; if (inst_valid !== 1'b1 || inst !== memword(30'h3F8)) begin
      n_err++; $display("FAIL drain_data got valid=%b inst=%h want 1 %h", inst_valid, inst, memword(30'h3F8)); end
  endtask

  task automatic test_redirect_beats_ready();
    do_reset(); step();
    imem_ack = 1'b1; imem_rdata = memword(30'h100);
    step();
    imem_ack = 1'b0;
    redirect = 1'b1; redirect_pc = 30'h080; inst_ready = 1'b1; next_pc = 30'h555;
    step();
    redirect = 1'b0; inst_ready = 1'b0;
    n_vec++; if (fetch_count !== 32'd0 || imem_addr !== 30'h080 || inst_valid !== 1'b0 || imem_req !== 1'b1) begin
      n_err++; $display("FAIL squash got count=%0d addr=%h valid=%b req=%b want 0 080 0 1",
                        fetch_count, imem_addr, inst_valid, imem_req); end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    redirect = 1'b1; redirect_pc = 30'h3FFF_FFFF;
    step();
    redirect = 1'b0;
    n_vec++; if (pc !== 30'h3FFF_FFFF || incr_pc !== 30'h0) begin
      n_err++; $display("FAIL wrap got pc=%h incr=%h want 3fffffff 0", pc, incr_pc); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_vec++; if (imem_req !== 1'b0 || inst_valid !== 1'b0 || pc !== 30'h100) begin
      n_err++; $display("FAIL mid_reset got req=%b valid=%b pc=%h want 0 0 100", imem_req, inst_valid, pc); end
  endtask

  // Model: the stream target address, the handshake count, and whether the
  // in-flight request was overtaken by a redirect (its data must be dropped).
  task automatic test_random();
    logic [29:0] m_pc, stale_addr;
    logic        stale, exp_valid, nv;
    logic [31:0] m_count;
    do_reset(); step();
    m_pc = 30'h100; stale = 1'b0; stale_addr = '0; exp_valid = 1'b0; m_count = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      n_vec++; if (inst_valid !== exp_valid) begin
        n_err++; $display("FAIL rnd_valid cyc%0d got %b want %b", cyc, inst_valid, exp_valid); end
      n_vec++; if (imem_req !== !exp_valid) begin
        n_err++; $display("FAIL rnd_req cyc%0d got %b want %b", cyc, imem_req, !exp_valid); end
      n_vec++; if (imem_addr !== (stale ? stale_addr : m_pc) || pc !== imem_addr) begin
        n_err++; $display("FAIL rnd_addr cyc%0d got addr=%h pc=%h want %h", cyc, imem_addr, pc, stale ? stale_addr : m_pc); end
      n_vec++; if (incr_pc !== pc + 30'd1) begin
        n_err++; $display("FAIL rnd_incr cyc%0d got %h want %h", cyc, incr_pc, pc + 30'd1); end
      n_vec++; if (fetch_count !== m_count) begin
        n_err++; $display("FAIL rnd_count cyc%0d got %0d want %0d", cyc, fetch_count, m_count); end
      if (exp_valid) begin
        n_vec++; if (inst !== memword(m_pc)) begin
          n_err++; $display("FAIL rnd_inst cyc%0d got %h want %h", cyc, inst, memword(m_pc)); end
      end
      imem_ack    = imem_req && ($urandom_range(0, 2) == 0);
      imem_rdata  = stale ? ~memword(imem_addr) : memword(imem_addr);
      redirect    = ($urandom_range(0, 7) == 0);
      redirect_pc = 30'($urandom);
      inst_ready  = $urandom_range(0, 1) == 1;
      next_pc     = ($urandom_range(0, 1) == 1) ? incr_pc : 30'($urandom);
      nv = 1'b0;
      if (redirect) begin
        if (imem_req && !imem_ack) begin
          if (!stale) stale_addr = imem_addr;
          stale = 1'b1;
        end else begin
          stale = 1'b0;
        end
        m_pc = redirect_pc;
      end else begin
        if (inst_valid && inst_ready) begin
          m_pc = next_pc; m_count = m_count + 32'd1;
        end else if (inst_valid) begin
          nv = 1'b1;
        end
        if (imem_req && imem_ack) begin
          if (!stale) nv = 1'b1;
          stale = 1'b0;
        end
      end
      exp_valid = nv;
      step();
    end
    imem_ack = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_drain();
    test_redirect_beats_ready();
    test_wrap_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the 30-bit word-addressed RISC core. It owns the architectural PC register and fetches one instruction at a time from instruction memory over a req/ack handshake. It presents the instruction to decode over a valid/ready handshake and loads the next-address logic's `NextPC` when decode accepts the instruction. It consumes what the next-address block produces: it drives `pc`/`incr_pc` into that block and takes `next_pc` back.

## Interface

Parameters:
- `RESET_PC`, default 30'h0000_0000, word address loaded into the PC on reset.

Ports:
- `clk`  in  1  Single clock; all state changes on the rising edge.
- `reset`  in  1  Synchronous, active-high reset.
- `next_pc`  in  30  Next word address from the next-address logic for the instruction in decode.
- `redirect`  in  1  One-cycle request to abandon the current stream (exception/vector).
- `redirect_pc`  in  30  Target word address, qualified by `redirect`.
- `imem_req`  out  1  Instruction-memory request (registered).
- `imem_addr`  out  30  Request word address, equal to `pc`.
- `imem_ack`  in  1  Memory completion pulse; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  Instruction word.
- `inst_valid`  out  1  Instruction available to decode (registered).
- `inst`  out  32  Held instruction word.
- `inst_ready`  in  1  Decode accepts `inst` this cycle.
- `pc`  out  30  Address of the instruction being fetched or held.
- `incr_pc`  out  30  `pc + 1`, modulo 2^30 (3FFF_FFFF + 1 = 0).
- `fetch_count`  out  32  Count of completed decode handshakes; wraps modulo 2^32.

## Operation

States: IDLE, FETCH, VALID, DRAIN.

- Reset (overrides everything): state=IDLE, `pc`=RESET_PC, `imem_req`=0, `inst_valid`=0, `inst`=0, `fetch_count`=0, pending PC=0.
- IDLE
  - Without `redirect`: go to FETCH; `imem_req` rises.
  - With `redirect`: load `pc`=`redirect_pc` first, then go to FETCH.
- FETCH (`imem_req`=1, `imem_addr`=`pc` held stable)
  - `imem_ack` and no `redirect`: capture `imem_rdata` into `inst`, drop `imem_req`, go to VALID.
  - `imem_ack` and `redirect`: discard the data, set `pc`=`redirect_pc`, stay in FETCH with `imem_req` held high. Back-to-back requests after an ack are legal.
  - `redirect` without `imem_ack`: latch `redirect_pc` as pending, go to DRAIN. Req and addr stay unchanged, because a request is never withdrawn or altered before its ack.
- DRAIN (`imem_req`=1, old address)
  - A new `redirect` overwrites the pending PC; the latest redirect wins.
  - `imem_ack`: discard the data, set `pc`=pending PC, or `redirect_pc` if `redirect` is high in the same cycle, then go to FETCH.
- VALID (`inst_valid`=1, `imem_req`=0)
  - `redirect`: squash the instruction, set `pc`=`redirect_pc`, go to FETCH, and do not increment `fetch_count`. Redirect beats `inst_ready`; decode must not commit while `redirect` is high.
  - `inst_ready` without `redirect`: set `pc`=`next_pc`, increment `fetch_count`, drop `inst_valid`, go to FETCH.
  - Otherwise hold `inst` and `pc` stable indefinitely.
- `imem_ack` outside FETCH/DRAIN is ignored.
- `imem_ack` and `imem_rdata` are not registered before use.

## Timing

- All outputs are registered except `incr_pc` and `imem_addr`, which are combinational from the `pc` register.
- First `imem_req` appears in the second cycle after `reset` deasserts: one cycle in IDLE.
- With a zero-wait memory (ack in the first cycle of req), throughput is 1 instruction per 2 cycles: FETCH, then VALID with `inst_ready`=1.
- `inst_valid` rises the cycle after the accepting `imem_ack`.
- `imem_addr` shows `next_pc` the cycle after the decode handshake.
- `next_pc` is sampled only in the handshake cycle. It may depend combinationally on `pc`/`incr_pc`; there is no combinational path from `next_pc` to any output.
- Redirect latency:
  - From VALID or FETCH-with-ack: `imem_addr`=`redirect_pc` on the next cycle.
  - From FETCH-without-ack: `imem_addr`=`redirect_pc` the cycle after the outstanding ack.
- Reset asserted mid-transaction aborts immediately. Memory must tolerate `imem_req` dropping without an ack in the reset cycle.

## Test plan

- Reset with RESET_PC=30'h100, memory acking in the first req cycle, `inst_ready`=1, `next_pc`=`incr_pc` → addresses 100,101,102 on successive FETCH cycles; `inst_valid` every other cycle; `fetch_count`=3 after three handshakes.
- Memory acks 3 cycles after req, `imem_rdata`=32'hDEAD_BEEF, `inst_ready`=0 for 5 cycles → `imem_addr` stable through the wait; `inst` holds DEAD_BEEF with `inst_valid`=1 for 5 cycles; `pc` unchanged; `fetch_count` unchanged.
- In VALID at pc=30'h200, `inst_ready`=1 with `next_pc`=30'h040 (branch) → next cycle `imem_addr`=040; `incr_pc`=041.
- `redirect` (`redirect_pc`=30'h3F0) at cycle 1 of a 4-cycle memory access to 30'h10, second `redirect` (30'h3F8) in DRAIN → `imem_addr` stays 10 until ack; that data is never presented; next request goes to 3F8.
- `redirect` (30'h080) and `inst_ready` both high in VALID → `fetch_count` not incremented; next `imem_addr`=080.
- `pc`=30'h3FFF_FFFF → `incr_pc`=0. Then assert `reset` during FETCH → next cycle `imem_req`=0, `inst_valid`=0, `pc`=RESET_PC.
